// File: rtl/pe_pkg.sv
// Shared types, default widths and the result clipping helper for the systolic PE.
package pe_pkg;

  localparam int PE_DW     = 16;
  localparam int PE_ACCW   = 40;
  localparam int PE_CW     = 8;
  localparam int PE_FDEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pe_state_e;

  typedef struct packed {
    logic             sat;
    logic [PE_DW-1:0] val;
  } clip_res_t;

  // Clip a wide signed accumulator into the signed PE_DW range and flag clipping.
  function automatic clip_res_t sat_clip(input logic signed [PE_ACCW-1:0] acc);
    logic signed [PE_ACCW-1:0] max_v;
    logic signed [PE_ACCW-1:0] min_v;
    clip_res_t                 res;
    max_v = {{(PE_ACCW-PE_DW+1){1'b0}}, {(PE_DW-1){1'b1}}};
    min_v = {{(PE_ACCW-PE_DW+1){1'b1}}, {(PE_DW-1){1'b0}}};
    if (acc > max_v) begin
      res.sat = 1'b1;
      res.val = {1'b0, {(PE_DW-1){1'b1}}};
    end else if (acc < min_v) begin
      res.sat = 1'b1;
      res.val = {1'b1, {(PE_DW-1){1'b0}}};
    end else begin
      res.sat = 1'b0;
      res.val = acc[PE_DW-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_fifo.sv
// Small synchronous operand FIFO. A push is visible at dout from the next cycle;
// a push while full is accepted only when a pop frees a slot in the same cycle.
module pe_fifo
  import pe_pkg::*;
#(
  parameter int DW     = PE_DW,
  parameter int FDEPTH = PE_FDEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] dout
);

  localparam int AW = $clog2(FDEPTH);

  logic [DW-1:0] mem_q [FDEPTH];
  logic [DW-1:0] mem_d [FDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_en_s;
  logic          rd_en_s;

  assign full    = (cnt_q == (AW+1)'(FDEPTH));
  assign empty   = (cnt_q == (AW+1)'(0));
  assign dout    = mem_q[rd_ptr_q];
  assign wr_en_s = push & (~full | pop);
  assign rd_en_s = pop & ~empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FDEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/systolic_pe.sv
// Signed MAC processing element for a 2-D systolic array. Operands queue in two
// FIFOs, are consumed pairwise while neither neighbour stalls, and are forwarded
// east/south. After max_cntr steps a clipped result is presented with a pulse.
module systolic_pe
  import pe_pkg::*;
#(
  parameter int DW     = PE_DW,
  parameter int FDEPTH = PE_FDEPTH,
  parameter int ACCW   = PE_ACCW,
  parameter int CW     = PE_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic          start,
  input  logic          awe,
  input  logic          bwe,
  input  logic          ais,
  input  logic          bis,
  output logic          aff,
  output logic          bff,
  output logic          se,
  output logic          fout,
  output logic          sat,
  output logic [DW-1:0] s_out,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic          start_next,
  input  logic [CW-1:0] max_cntr
);

  pe_state_e              state_q, state_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DW-1:0]          a_out_q, a_out_d;
  logic [DW-1:0]          b_out_q, b_out_d;
  logic [DW-1:0]          s_out_q, s_out_d;
  logic                   se_q, se_d;
  logic                   fout_q, fout_d;
  logic                   sat_q, sat_d;
  logic                   start_next_q, start_next_d;

  logic                   a_empty_s, b_empty_s;
  logic [DW-1:0]          a_dout_s, b_dout_s;
  logic                   step_s;
  logic signed [2*DW-1:0] prod_s;
  logic signed [ACCW-1:0] prod_ext_s;
  clip_res_t              clip_s;

  pe_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_a_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (awe),
    .pop   (step_s),
    .din   (a_in),
    .full  (aff),
    .empty (a_empty_s),
    .dout  (a_dout_s)
  );

  pe_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_b_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bwe),
    .pop   (step_s),
    .din   (b_in),
    .full  (bff),
    .empty (b_empty_s),
    .dout  (b_dout_s)
  );

  // A step needs both operands, no downstream stall, work left, and no start
  // (a start in the same cycle takes priority and suppresses the MAC).
  assign step_s = (state_q == ST_RUN) & ~a_empty_s & ~b_empty_s & ~ais & ~bis &
                  (cnt_q != CW'(0)) & ~start;

  assign prod_s     = $signed(a_dout_s) * $signed(b_dout_s);
  assign prod_ext_s = {{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s};
  assign clip_s     = sat_clip(acc_q);

  // FSM and MAC datapath next-state.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    a_out_d      = a_out_q;
    b_out_d      = b_out_q;
    s_out_d      = s_out_q;
    sat_d        = sat_q;
    se_d         = 1'b0;
    fout_d       = 1'b0;
    start_next_d = start;
    if (start) begin
      acc_d   = {ACCW{1'b0}};
      cnt_d   = max_cntr;
      state_d = (max_cntr == CW'(0)) ? ST_DONE : ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (step_s) begin
            acc_d   = acc_q + prod_ext_s;
            cnt_d   = cnt_q - CW'(1);
            a_out_d = a_dout_s;
            b_out_d = b_dout_s;
            se_d    = 1'b1;
            state_d = (cnt_q == CW'(1)) ? ST_DONE : ST_RUN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          fout_d  = 1'b1;
          s_out_d = clip_s.val;
          sat_d   = clip_s.sat;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= {ACCW{1'b0}};
      cnt_q        <= {CW{1'b0}};
      a_out_q      <= {DW{1'b0}};
      b_out_q      <= {DW{1'b0}};
      s_out_q      <= {DW{1'b0}};
      sat_q        <= 1'b0;
      se_q         <= 1'b0;
      fout_q       <= 1'b0;
      start_next_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      a_out_q      <= a_out_d;
      b_out_q      <= b_out_d;
      s_out_q      <= s_out_d;
      sat_q        <= sat_d;
      se_q         <= se_d;
      fout_q       <= fout_d;
      start_next_q <= start_next_d;
    end
  end

  assign se         = se_q;
  assign fout       = fout_q;
  assign sat        = sat_q;
  assign s_out      = s_out_q;
  assign a_out      = a_out_q;
  assign b_out      = b_out_q;
  assign start_next = start_next_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Directed self-checking bench for systolic_pe.
module tb_systolic_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_in, b_in;
  logic        start, awe, bwe, ais, bis;
  logic        aff, bff, se, fout, sat, start_next;
  logic [15:0] s_out, a_out, b_out;
  logic [7:0]  max_cntr;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int se_seen     = 0;
  int fout_seen   = 0;
  int last_se     = 0;
  int fout_cyc    = 0;
  int base_se;
  int base_f;
  logic [15:0] fout_s;
  logic        fout_sat;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  systolic_pe dut (
    .clk        (clk),
    .rst        (rst),
    .a_in       (a_in),
    .b_in       (b_in),
    .start      (start),
    .awe        (awe),
    .bwe        (bwe),
    .ais        (ais),
    .bis        (bis),
    .aff        (aff),
    .bff        (bff),
    .se         (se),
    .fout       (fout),
    .sat        (sat),
    .s_out      (s_out),
    .a_out      (a_out),
    .b_out      (b_out),
    .start_next (start_next),
    .max_cntr   (max_cntr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; sample outputs 1 time unit after the edge and track se/fout events.
  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    if (se) begin
      se_seen++;
      last_se = cycle;
      if (exp_a.size() > 0) begin
        check("a_out", {16'd0, a_out}, {16'd0, exp_a.pop_front()});
        check("b_out", {16'd0, b_out}, {16'd0, exp_b.pop_front()});
      end else begin
        check("se_unexpected", 32'd1, 32'd0);
      end
    end
    if (fout) begin
      fout_seen++;
      fout_cyc = cycle;
      fout_s   = s_out;
      fout_sat = sat;
    end
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    a_in = a;
    b_in = b;
    awe  = 1'b1;
    bwe  = 1'b1;
    cyc();
    awe  = 1'b0;
    bwe  = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    max_cntr = n;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
    check("start_next_hi", {31'd0, start_next}, 32'd1);
  endtask

  task automatic wait_fout(input int fbase, input int budget, input string tag);
    int n = 0;
    while (fout_seen == fbase && n < budget) begin
      cyc();
      n++;
    end
    check({tag, "_fout_seen"}, (fout_seen != fbase) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic expect_pair(input logic [15:0] a, input logic [15:0] b);
    exp_a.push_back(a);
    exp_b.push_back(b);
  endtask

  initial begin
    rst = 1'b1; a_in = 16'd0; b_in = 16'd0; start = 1'b0; awe = 1'b0; bwe = 1'b0;
    ais = 1'b0; bis = 1'b0; max_cntr = 8'd0;
    #12;
    check("rst_aff", {31'd0, aff}, 32'd0);
    check("rst_fout", {31'd0, fout}, 32'd0);
    check("rst_s_out", {16'd0, s_out}, 32'd0);
    check("rst_start_next", {31'd0, start_next}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Saturating run of four steps; a fifth pair stays queued.
    base_se = se_seen; base_f = fout_seen;
    expect_pair(16'd100, 16'd200); expect_pair(16'd200, 16'd130);
    expect_pair(16'd255, 16'd256); expect_pair(16'd100, 16'd300);
    pulse_start(8'd4);
    cyc();
    check("start_next_lo", {31'd0, start_next}, 32'd0);
    push_pair(16'd100, 16'd200); push_pair(16'd200, 16'd130);
    push_pair(16'd255, 16'd256); push_pair(16'd100, 16'd300);
    push_pair(16'd0, 16'd0);
    wait_fout(base_f, 20, "t2");
    check("t2_s_out", {16'd0, fout_s}, 32'h0000_7FFF);
    check("t2_sat", {31'd0, fout_sat}, 32'd1);
    check("t2_latency", fout_cyc - last_se, 32'd1);
    check("t2_steps", se_seen - base_se, 32'd4);
    repeat (3) cyc();
    check("t2_single_fout", fout_seen - base_f, 32'd1);

    // Drain the queued (0,0) pair with a one-step run.
    base_se = se_seen; base_f = fout_seen;
    expect_pair(16'd0, 16'd0);
    pulse_start(8'd1);
    wait_fout(base_f, 10, "drain");
    check("drain_steps", se_seen - base_se, 32'd1);
    check("drain_s_out", {16'd0, fout_s}, 32'd0);
    check("drain_sat", {31'd0, fout_sat}, 32'd0);

    // Negative result without clipping.
    base_se = se_seen; base_f = fout_seen;
    expect_pair(16'd3, 16'hFFFC); expect_pair(16'hFFFB, 16'd6);
    pulse_start(8'd2);
    push_pair(16'd3, 16'hFFFC);
    push_pair(16'hFFFB, 16'd6);
    wait_fout(base_f, 10, "t3");
    check("t3_s_out", {16'd0, fout_s}, 32'h0000_FFD6);
    check("t3_sat", {31'd0, fout_sat}, 32'd0);
    check("t3_latency", fout_cyc - last_se, 32'd1);
    repeat (3) cyc();
    check("t3_single_fout", fout_seen - base_f, 32'd1);

    // Zero-length run goes straight to DONE.
    pulse_start(8'd0);
    check("t6_no_fout_yet", {31'd0, fout}, 32'd0);
    cyc();
    check("t6_fout", {31'd0, fout}, 32'd1);
    check("t6_s_out", {16'd0, s_out}, 32'd0);
    check("t6_sat", {31'd0, sat}, 32'd0);
    cyc();
    check("t6_fout_pulse", {31'd0, fout}, 32'd0);

    // East stall holds off steps; result unaffected once released.
    base_se = se_seen; base_f = fout_seen;
    expect_pair(16'd7, 16'd8); expect_pair(16'd9, 16'hFFF6);
    ais = 1'b1;
    pulse_start(8'd2);
    push_pair(16'd7, 16'd8);
    push_pair(16'd9, 16'hFFF6);
    repeat (4) cyc();
    check("t5_stalled", se_seen - base_se, 32'd0);
    ais = 1'b0;
    wait_fout(base_f, 10, "t5");
    check("t5_steps", se_seen - base_se, 32'd2);
    check("t5_s_out", {16'd0, fout_s}, 32'h0000_FFDE);
    check("t5_sat", {31'd0, fout_sat}, 32'd0);

    // Fill in IDLE: full after four pushes, fifth dropped.
    base_se = se_seen; base_f = fout_seen;
    for (int i = 0; i < 5; i++) begin
      a_in = 16'(11 + i);
      b_in = 16'(21 + i);
      awe  = 1'b1;
      bwe  = 1'b1;
      cyc();
      check("t4_aff", {31'd0, aff}, (i >= 3) ? 32'd1 : 32'd0);
      check("t4_bff", {31'd0, bff}, (i >= 3) ? 32'd1 : 32'd0);
    end
    awe = 1'b0; bwe = 1'b0;
    check("t4_idle_no_se", se_seen - base_se, 32'd0);
    for (int i = 0; i < 4; i++) begin
      expect_pair(16'(11 + i), 16'(21 + i));
    end
    pulse_start(8'd5);
    repeat (8) cyc();
    check("t4_steps", se_seen - base_se, 32'd4);
    check("t4_no_fout", fout_seen - base_f, 32'd0);
    check("t4_aff_drained", {31'd0, aff}, 32'd0);

    // Reset in the middle of the stuck run.
    rst = 1'b1;
    #2;
    check("mid_rst_a_out", {16'd0, a_out}, 32'd0);
    check("mid_rst_b_out", {16'd0, b_out}, 32'd0);
    check("mid_rst_s_out", {16'd0, s_out}, 32'd0);
    check("mid_rst_se_fout_sat", {29'd0, se, fout, sat}, 32'd0);
    cyc();
    rst = 1'b0;
    exp_a.delete();
    exp_b.delete();
    cyc();
    base_se = se_seen; base_f = fout_seen;
    expect_pair(16'd2, 16'd3);
    pulse_start(8'd1);
    push_pair(16'd2, 16'd3);
    wait_fout(base_f, 10, "post_rst");
    check("post_rst_steps", se_seen - base_se, 32'd1);
    check("post_rst_s_out", {16'd0, fout_s}, 32'd6);
    check("post_rst_sat", {31'd0, fout_sat}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
